imem_arbiter: RTL and testbench

Shares one single-port synchronous instruction memory between two requesters: the CPU fetch stage and a program loader/debug port.
- The loader may write words (program load) or read them back.
- Fetch only reads.
- Arbitration is loader-priority, with a starvation limit that guarantees fetch forward progress; an optional lock holds fetch off during bulk loads.
- Sits between the fetch stage and the instruction memory array; zero-fills out-of-range reads so fetch never sees X.

---
 rtl/imem_arbiter_if.sv | 54 +++++
 rtl/imem_arbiter.sv | 132 +++++++++++++
 tb/tb_imem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_arbiter_if
//  Description : Bundle of the fetch, loader and memory-side signals around
//                the instruction memory arbiter. The arbiter sits on the
//                slave modport. The fetch stage, loader and memory array
//                together sit on the master modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_arbiter_if #(
    parameter int DEPTH_LOG2 = 11
);
    // fetch requester
    logic                  fetch_req;
    logic [31:0]           fetch_addr;
    logic                  fetch_gnt;
    logic                  fetch_rvalid;
    logic [31:0]           fetch_rdata;
    // loader / debug requester
    logic                  ld_req;
    logic                  ld_we;
    logic [31:0]           ld_addr;
    logic [31:0]           ld_wdata;
    logic                  ld_lock;
    logic                  ld_gnt;
    logic                  ld_rvalid;
    logic [31:0]           ld_rdata;
    logic                  oor_err;
    // single-port memory
    logic                  mem_en;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr,
        output fetch_gnt, fetch_rvalid, fetch_rdata,
        input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        output ld_gnt, ld_rvalid, ld_rdata, oor_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output fetch_req, fetch_addr,
        input  fetch_gnt, fetch_rvalid, fetch_rdata,
        output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        input  ld_gnt, ld_rvalid, ld_rdata, oor_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : imem_arbiter
//  Description : Shares one single-port synchronous instruction memory
//                between the CPU fetch stage and a program loader. The loader
//                has priority. A starvation counter guarantees that fetch
//                still makes progress. ld_lock holds fetch off completely.
//                Out-of-range reads return zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
    parameter int DEPTH_LOG2 = 11,
    parameter int MAX_STALL  = 4
) (
    input  logic          clk,
    input  logic          rst,
    imem_arbiter_if.slave bus
);

    // source tag of the read whose data returns this cycle
    localparam logic [1:0] c_TAG_NONE  = 2'd0;
    localparam logic [1:0] c_TAG_FETCH = 2'd1;
    localparam logic [1:0] c_TAG_LD    = 2'd2;
    localparam logic [3:0] c_MAX_STALL = 4'(MAX_STALL);

    logic [3:0]  r_starve_cnt;
    logic [1:0]  r_tag;
    logic        r_oor_rd;
    logic        r_oor_err;
    logic [31:0] r_fetch_hold;
    logic [31:0] r_ld_hold;

    logic        w_fetch_gnt;
    logic        w_ld_gnt;
    logic        w_any_gnt;
    logic        w_fetch_inr;
    logic        w_ld_inr;
    logic        w_gnt_inr;
    logic [31:0] w_gnt_addr;
    logic [31:0] w_rd_data;
    logic        w_fetch_rvalid;
    logic        w_ld_rvalid;
    logic        w_unused;

    // byte-offset bits carry no meaning for word accesses
    assign w_unused = ^{bus.fetch_addr[1:0], bus.ld_addr[1:0]};

    assign w_fetch_inr = (bus.fetch_addr[31:DEPTH_LOG2+2] == '0);
    assign w_ld_inr    = (bus.ld_addr[31:DEPTH_LOG2+2] == '0);

    // Priority: lock > starved fetch > loader > fetch. Grants are dead in reset.
    always_comb begin
        w_fetch_gnt = 1'b0;
        w_ld_gnt    = 1'b0;
        if (!rst) begin
            if (bus.ld_lock) begin
                w_ld_gnt = bus.ld_req;
            end else if ((r_starve_cnt == c_MAX_STALL) && bus.fetch_req) begin
                w_fetch_gnt = 1'b1;
            end else if (bus.ld_req) begin
                w_ld_gnt = 1'b1;
            end else if (bus.fetch_req) begin
                w_fetch_gnt = 1'b1;
            end
        end
    end

    assign w_any_gnt  = w_fetch_gnt | w_ld_gnt;
    assign w_gnt_addr = w_ld_gnt ? bus.ld_addr : bus.fetch_addr;
    assign w_gnt_inr  = w_ld_gnt ? w_ld_inr : w_fetch_inr;

    // An out-of-range access is granted but never reaches the array.
    assign bus.fetch_gnt = w_fetch_gnt;
    assign bus.ld_gnt    = w_ld_gnt;
    assign bus.mem_en    = w_any_gnt & w_gnt_inr;
    assign bus.mem_we    = w_ld_gnt & w_ld_inr & bus.ld_we;
    assign bus.mem_addr  = w_any_gnt ? w_gnt_addr[DEPTH_LOG2+1:2] : '0;
    assign bus.mem_wdata = w_ld_gnt ? bus.ld_wdata : '0;

    // Return path: the tag steers mem_rdata. Out-of-range reads return zero.
    assign w_rd_data      = r_oor_rd ? 32'h0 : bus.mem_rdata;
    assign w_fetch_rvalid = (r_tag == c_TAG_FETCH);
    assign w_ld_rvalid    = (r_tag == c_TAG_LD);

    assign bus.fetch_rvalid = w_fetch_rvalid;
    assign bus.ld_rvalid    = w_ld_rvalid;
    assign bus.fetch_rdata  = w_fetch_rvalid ? w_rd_data : r_fetch_hold;
    assign bus.ld_rdata     = w_ld_rvalid ? w_rd_data : r_ld_hold;
    assign bus.oor_err      = r_oor_err;

    // Track the in-flight read, the sticky range error and the held rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag        <= c_TAG_NONE;
            r_oor_rd     <= 1'b0;
            r_oor_err    <= 1'b0;
            r_fetch_hold <= 32'h0;
            r_ld_hold    <= 32'h0;
        end else begin
            if (w_fetch_gnt) begin
                r_tag <= c_TAG_FETCH;
            end else if (w_ld_gnt && !bus.ld_we) begin
                r_tag <= c_TAG_LD;
            end else begin
                r_tag <= c_TAG_NONE;
            end
            r_oor_rd <= !w_gnt_inr;
            if (w_any_gnt && !w_gnt_inr) begin
                r_oor_err <= 1'b1;
            end
            if (w_fetch_rvalid) begin
                r_fetch_hold <= w_rd_data;
            end
            if (w_ld_rvalid) begin
                r_ld_hold <= w_rd_data;
            end
        end
    end

    // Count consecutive denied fetch cycles. The count is frozen while locked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (!bus.fetch_req || w_fetch_gnt) begin
            r_starve_cnt <= 4'd0;
        end else if (!bus.ld_lock) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_arbiter
//  Description : Self-checking bench for imem_arbiter. It has three parts: a
//                vector table, hand-written reset sequences, and randomized
//                traffic. Every check compares against a behavioural model
//                held in the bench.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;

    localparam int DL    = 11;
    localparam int DEPTH = 1 << DL;
    localparam int MS    = 4;

    logic clk;
    logic rst;

    imem_arbiter_if #(.DEPTH_LOG2(DL)) bus ();

    imem_arbiter #(.DEPTH_LOG2(DL), .MAX_STALL(MS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        logic [31:0] ii;
        ii = i;
        return (ii * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // memory array the arbiter drives (initialised with a known pattern)
    logic [31:0] env_mem [0:DEPTH-1];
    logic        env_ready;
    always @(posedge clk) begin
        if (env_ready !== 1'b1) begin
            for (int i = 0; i < DEPTH; i++) env_mem[i] <= pat(i);
            env_ready <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) env_mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= env_mem[bus.mem_addr];
        end
    end

    // ---------------- reference model state ----------------
    logic [31:0] ref_mem [0:DEPTH-1];
    int          m_streak;
    bit          m_oor, m_fv, m_lv;
    logic [31:0] m_fd, m_ld, m_flast, m_llast;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic        freq;
        logic [31:0] faddr;
        logic        lreq;
        logic        lwe;
        logic [31:0] laddr;
        logic [31:0] lwdata;
        logic        lock;
        logic        e_fgnt;
        logic        e_lgnt;
        logic        e_en;
        logic        e_we;
        logic [10:0] e_addr;
        logic        e_frv;
        logic [31:0] e_frd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic fr, input logic [31:0] fa,
                                input logic lr, input logic lw, input logic [31:0] la,
                                input logic [31:0] ld, input logic lk,
                                input logic ef, input logic el, input logic een,
                                input logic ewe, input logic [10:0] ea,
                                input logic efrv, input logic [31:0] efrd);
        vec_t v;
        v.freq = fr; v.faddr = fa; v.lreq = lr; v.lwe = lw; v.laddr = la;
        v.lwdata = ld; v.lock = lk; v.e_fgnt = ef; v.e_lgnt = el; v.e_en = een;
        v.e_we = ewe; v.e_addr = ea; v.e_frv = efrv; v.e_frd = efrd;
        return v;
    endfunction

    function automatic vec_t idle_vec();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic bit inr(input logic [31:0] a);
        return (a >> (DL + 2)) == 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_streak = 0; m_oor = 0; m_fv = 0; m_lv = 0;
        m_fd = 0; m_ld = 0; m_flast = 0; m_llast = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " fetch_gnt"},    bus.fetch_gnt, 0);
        chk({tag, " ld_gnt"},       bus.ld_gnt, 0);
        chk({tag, " mem_en"},       bus.mem_en, 0);
        chk({tag, " mem_we"},       bus.mem_we, 0);
        chk({tag, " mem_addr"},     32'(bus.mem_addr), 0);
        chk({tag, " mem_wdata"},    bus.mem_wdata, 0);
        chk({tag, " fetch_rvalid"}, bus.fetch_rvalid, 0);
        chk({tag, " fetch_rdata"},  bus.fetch_rdata, 0);
        chk({tag, " ld_rvalid"},    bus.ld_rvalid, 0);
        chk({tag, " ld_rdata"},     bus.ld_rdata, 0);
        chk({tag, " oor_err"},      bus.oor_err, 0);
    endtask

    // One clock cycle: drive at negedge, check mid-cycle, advance model at posedge.
    task automatic run_cycle(input vec_t v, input bit use_tbl, output bit gf, output bit gl);
        bit          ef, el, f_in, l_in, g_in, e_en, e_we;
        logic [31:0] ga;
        logic [DL-1:0] e_addr, fidx, lidx;
        @(negedge clk);
        bus.fetch_req  = v.freq;
        bus.fetch_addr = v.faddr;
        bus.ld_req     = v.lreq;
        bus.ld_we      = v.lwe;
        bus.ld_addr    = v.laddr;
        bus.ld_wdata   = v.lwdata;
        bus.ld_lock    = v.lock;
        #1;
        f_in = inr(v.faddr);
        l_in = inr(v.laddr);
        if (rst) begin
            ef = 0;
            el = 0;
        end else begin
            ef = !v.lock && v.freq && (m_streak >= MS || !v.lreq);
            el = v.lreq && !ef;
        end
        g_in   = el ? l_in : f_in;
        e_en   = (ef || el) && g_in;
        e_we   = el && v.lwe && l_in;
        ga     = el ? v.laddr : v.faddr;
        e_addr = ga[DL+1:2];
        fidx   = v.faddr[DL+1:2];
        lidx   = v.laddr[DL+1:2];

        chk("fetch_gnt", bus.fetch_gnt, ef);
        chk("ld_gnt",    bus.ld_gnt, el);
        chk("mem_en",    bus.mem_en, e_en);
        chk("mem_we",    bus.mem_we, e_we);
        if (e_en) chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        if (e_we) chk("mem_wdata", bus.mem_wdata, v.lwdata);
        chk("fetch_rvalid", bus.fetch_rvalid, m_fv);
        chk("fetch_rdata",  bus.fetch_rdata, m_fv ? m_fd : m_flast);
        chk("ld_rvalid",    bus.ld_rvalid, m_lv);
        chk("ld_rdata",     bus.ld_rdata, m_lv ? m_ld : m_llast);
        chk("oor_err",      bus.oor_err, m_oor);
        if (use_tbl) begin
            chk("tbl fetch_gnt",    bus.fetch_gnt, v.e_fgnt);
            chk("tbl ld_gnt",       bus.ld_gnt, v.e_lgnt);
            chk("tbl mem_en",       bus.mem_en, v.e_en);
            chk("tbl mem_we",       bus.mem_we, v.e_we);
            if (v.e_en) chk("tbl mem_addr", 32'(bus.mem_addr), 32'(v.e_addr));
            chk("tbl fetch_rvalid", bus.fetch_rvalid, v.e_frv);
            if (v.e_frv) chk("tbl fetch_rdata", bus.fetch_rdata, v.e_frd);
        end
        gf = ef;
        gl = el;

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_fv) m_flast = m_fd;
            if (m_lv) m_llast = m_ld;
            m_fv = ef;
            m_fd = f_in ? ref_mem[fidx] : 32'h0;
            m_lv = el && !v.lwe;
            m_ld = l_in ? ref_mem[lidx] : 32'h0;
            if (el && v.lwe && l_in) ref_mem[lidx] = v.lwdata;
            if ((ef && !f_in) || (el && !l_in)) m_oor = 1;
            if (ef || !v.freq) m_streak = 0;
            else if (!v.lock)  m_streak++;
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 99) < 8) return $urandom | 32'h0001_0000;
        return {25'h0, 5'($urandom_range(0, 31)), 2'($urandom)};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit gf, gl, f_pend, l_pend;
        vec_t v, rv;
        int lock_t;

        rst = 1'b1;
        bus.fetch_req = 0; bus.fetch_addr = 0; bus.ld_req = 0; bus.ld_we = 0;
        bus.ld_addr = 0; bus.ld_wdata = 0; bus.ld_lock = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.fetch_req = 1; bus.ld_req = 1;
        #1;
        check_zero("reset");
        bus.fetch_req = 0; bus.ld_req = 0;
        @(negedge clk);
        rst = 1'b0;

        // ---- vector table ----
        // plain fetch stream
        tbl.push_back(mk(1, 32'h0,  0, 0, 0, 0, 0,  1, 0, 1, 0, 11'd0, 0, 0));
        tbl.push_back(mk(1, 32'h4,  0, 0, 0, 0, 0,  1, 0, 1, 0, 11'd1, 1, pat(0)));
        tbl.push_back(mk(1, 32'h8,  0, 0, 0, 0, 0,  1, 0, 1, 0, 11'd2, 1, pat(1)));
        // loader write then fetch read-back of the new word
        tbl.push_back(mk(1, 32'h10, 1, 1, 32'h10, 32'hDEADBEEF, 0,  0, 1, 1, 1, 11'd4, 1, pat(2)));
        tbl.push_back(mk(1, 32'h10, 0, 0, 0, 0, 0,  1, 0, 1, 0, 11'd4, 0, 0));
        tbl.push_back(mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 0, 0, 11'd0, 1, 32'hDEADBEEF));
        // starvation: loader wins 4 times, fetch on the 5th
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 32'h40, 1, 0, 32'h20, 0, 0,  0, 1, 1, 0, 11'd8, 0, 0));
        tbl.push_back(mk(1, 32'h40, 1, 0, 32'h20, 0, 0,  1, 0, 1, 0, 11'd16, 0, 0));
        tbl.push_back(mk(1, 32'h40, 1, 0, 32'h20, 0, 0,  0, 1, 1, 0, 11'd8, 1, pat(16)));
        // lock for 10 cycles: fetch never granted
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1, 32'h40, 1, 0, 32'h20, 0, 1,  0, 1, 1, 0, 11'd8, 0, 0));
        // lock released: counter resumes from 1, fetch wins within MAX_STALL+1
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 32'h40, 1, 0, 32'h20, 0, 0,  0, 1, 1, 0, 11'd8, 0, 0));
        tbl.push_back(mk(1, 32'h40, 1, 0, 32'h20, 0, 0,  1, 0, 1, 0, 11'd16, 0, 0));
        tbl.push_back(mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 0, 0, 11'd0, 1, pat(16)));
        // out of range: fetch word 2048, loader write 0x4000
        tbl.push_back(mk(1, 32'h2000, 0, 0, 0, 0, 0,  1, 0, 0, 0, 11'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 32'h4000, 32'h12345678, 0,  0, 1, 0, 0, 11'd0, 1, 32'h0));
        tbl.push_back(mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 0, 0, 11'd0, 0, 0));

        foreach (tbl[i]) run_cycle(tbl[i], 1'b1, gf, gl);
        chk("oor_err sticky", bus.oor_err, 1);

        // ---- reset right after a granted fetch read ----
        v = idle_vec();
        v.freq = 1; v.faddr = 32'h8;
        run_cycle(v, 1'b0, gf, gl);
        #1 rst = 1'b1;
        model_reset();
        #1;
        check_zero("async rst");
        v = idle_vec();
        v.freq = 1; v.lreq = 1; v.laddr = 32'h20;
        run_cycle(v, 1'b0, gf, gl);
        run_cycle(v, 1'b0, gf, gl);
        run_cycle(idle_vec(), 1'b0, gf, gl);
        rst = 1'b0;
        v = idle_vec();
        v.freq = 1; v.faddr = 32'hC;
        run_cycle(v, 1'b0, gf, gl);
        chk("post-rst grant", 32'(gf), 1);
        run_cycle(idle_vec(), 1'b0, gf, gl);

        // ---- randomized traffic ----
        f_pend = 0; l_pend = 0; lock_t = 0;
        rv = idle_vec();
        for (int c = 0; c < 800; c++) begin
            if (!f_pend) begin
                f_pend   = ($urandom_range(0, 99) < 60);
                rv.faddr = rnd_addr();
            end
            if (!l_pend) begin
                l_pend    = ($urandom_range(0, 99) < 45);
                rv.lwe    = 1'($urandom);
                rv.laddr  = rnd_addr();
                rv.lwdata = $urandom;
            end
            if (lock_t == 0 && $urandom_range(0, 99) < 3) lock_t = $urandom_range(3, 12);
            rv.lock = (lock_t > 0);
            if (lock_t > 0) lock_t--;
            rv.freq = f_pend;
            rv.lreq = l_pend;
            run_cycle(rv, 1'b0, gf, gl);
            if (gf) f_pend = 0;
            if (gl) l_pend = 0;
        end
        run_cycle(idle_vec(), 1'b0, gf, gl);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
